mul_iter: RTL and testbench



---
 rtl/mul_iter_pkg.sv | 20 ++
 rtl/mul_iter_if.sv | 23 ++
 rtl/mul_iter_step.sv | 13 +
 rtl/mul_iter.sv | 108 ++++++++++
 tb/tb_mul_iter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mul_iter_pkg.sv
// Shared types and defaults for the iterative multiplier (mul_iter) and its bench.
package mul_iter_pkg;

  localparam int XLEN_DEF = 32;
  localparam int STEP_DEF = 4;

  // Encoding 2'b11 is not listed; it behaves as MUL_UU.
  typedef enum logic [1:0] {
    MUL_UU = 2'd0,
    MUL_SS = 2'd1,
    MUL_SU = 2'd2
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

endpackage

// File: rtl/mul_iter_if.sv
// Request/response bundle of mul_iter: valid/ready request with operands, valid/ready product.
interface mul_iter_if #(
  parameter int XLEN = mul_iter_pkg::XLEN_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [2*XLEN-1:0] p;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/mul_iter_step.sv
// One radix-2^STEP digit step: unsigned mag_a times a STEP-bit multiplier digit.
module mul_step #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic [XLEN-1:0]      mag_a_i,
  input  logic [STEP-1:0]      digit_i,
  output logic [XLEN+STEP-1:0] pp_o
);

  assign pp_o = (XLEN+STEP)'(mag_a_i) * (XLEN+STEP)'(digit_i);

endmodule

// File: rtl/mul_iter.sv
// Iterative sign-magnitude multiplier retiring STEP multiplier bits per BUSY cycle.
// Define MUL_ITER_EARLY_EN to leave BUSY as soon as the remaining multiplier bits are zero.
module mul_iter
  import mul_iter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int STEP = STEP_DEF
) (
  input logic       clock,
  input logic       reset,
  mul_iter_if.slave bus
);

  localparam int N     = XLEN / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  mul_state_t          state_q, state_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   p_q, p_d;
  logic [XLEN-1:0]     mag_a_q, mag_a_d;
  logic [XLEN-1:0]     mag_b_q, mag_b_d;
  logic                neg_q, neg_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [XLEN+STEP-1:0] pp;
  logic                a_neg, b_neg, last_step;

  // Only operands interpreted as signed contribute a sign; op 2'b11 falls to unsigned.
  assign a_neg = ((bus.op == MUL_SS) || (bus.op == MUL_SU)) && bus.a[XLEN-1];
  assign b_neg = (bus.op == MUL_SS) && bus.b[XLEN-1];

  mul_step #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_step (
    .mag_a_i (mag_a_q),
    .digit_i (mag_b_q[STEP-1:0]),
    .pp_o    (pp)
  );

`ifdef MUL_ITER_EARLY_EN
  assign last_step = (count_q == CNT_W'(N-1)) || ((mag_b_q >> STEP) == '0);
`else
  assign last_step = (count_q == CNT_W'(N-1));
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    p_d     = p_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mag_a_d = a_neg ? -bus.a : bus.a;
          mag_b_d = b_neg ? -bus.b : bus.b;
          neg_d   = a_neg ^ b_neg;
          acc_d   = '0;
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // mag_b is consumed from the bottom, so the digit always sits in its low STEP bits.
        acc_d   = acc_q + ((2*XLEN)'(pp) << (STEP * int'(count_q)));
        mag_b_d = mag_b_q >> STEP;
        count_d = count_q + CNT_W'(1);
        if (last_step) begin
          p_d     = neg_q ? -acc_d : acc_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      p_q     <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.p         = p_q;

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed corner cases plus a random sweep against a
// full-width integer product model; latency expectation follows MUL_ITER_EARLY_EN.
module tb_mul_iter;
  import mul_iter_pkg::*;

  localparam int XLEN = 32;
  localparam int STEP = 4;
  localparam int N    = XLEN / STEP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_iter_if #(.XLEN(XLEN)) bus ();

  mul_iter #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands per mode, multiply as 64-bit integers, keep 64 bits.
  function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    bit a_s, b_s;
    a_s = (op == 2'd1) || (op == 2'd2);
    b_s = (op == 2'd1);
    sa  = a_s ? longint'($signed(a)) : longint'(a);
    sb  = b_s ? longint'($signed(b)) : longint'(b);
    return 64'(sa * sb);
  endfunction

  // Negedges from the accept edge until out_valid is first seen (BUSY cycles + 1).
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MUL_ITER_EARLY_EN
    logic [31:0] mag;
    int msb, busy;
    mag = (op == 2'd1 && b[31]) ? -b : b;
    msb = -1;
    for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
    busy = (msb + 1 + STEP - 1) / STEP;
    if (busy < 1) busy = 1;
    return busy + 1;
`else
    return N + 1;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom >> $urandom_range(0, 31);
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) check("accept_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic collect(output logic [63:0] p, output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.out_valid && bus.in_ready) busy_ok = 1'b0;
    end while (!bus.out_valid && lat < 64);
    p = bus.p;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit full);
    logic [63:0] p;
    int lat;
    bit busy_ok;
    send(op, a, b);
    collect(p, lat, busy_ok);
    check({tag, "_p"}, p, ref_mul(op, a, b));
    check({tag, "_lat"}, lat, exp_lat(op, b));
    if (full) check({tag, "_busy_ready"}, busy_ok, 1'b1);
    release_out();
    if (full) begin
      check({tag, "_valid_drop"}, bus.out_valid, 1'b0);
      check({tag, "_ready_back"}, bus.in_ready, 1'b1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p0, p1;
    int lat;
    bit busy_ok, hold_ok, seen_valid;
    logic [1:0]  op;
    logic [31:0] a, b;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 2'd0; bus.a = '0; bus.b = '0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_p", bus.p, 64'h0);
    rst_n = 1'b1;

    run_op("uu_3x5", 2'd0, 32'd3, 32'd5, 1'b1);
    check("uu_3x5_const", bus.p, 64'h0000_0000_0000_000F);
    run_op("uu_ones", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("uu_ones_const", bus.p, 64'hFFFF_FFFE_0000_0001);
    run_op("ss_ones", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("ss_ones_const", bus.p, 64'h0000_0000_0000_0001);
    run_op("su_ones", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("su_ones_const", bus.p, 64'hFFFF_FFFF_0000_0001);
    run_op("ss_min", 2'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    check("ss_min_const", bus.p, 64'h4000_0000_0000_0000);
    run_op("op11_ones", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op("ss_neg_pos", 2'd1, 32'hFFFF_FFF9, 32'd6, 1'b1);
    run_op("early_f", 2'd0, 32'h1234_5678, 32'h0000_000F, 1'b1);
    run_op("b_zero", 2'd0, 32'h1234_5678, 32'h0, 1'b1);
    check("b_zero_const", bus.p, 64'h0);

    // Backpressure: product held in DONE while a new request waits on in_valid.
    send(2'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    collect(p0, lat, busy_ok);
    check("bp_first_p", p0, ref_mul(2'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D));
    bus.op = 2'd0; bus.a = 32'd1000; bus.b = 32'd77; bus.in_valid = 1'b1;
    hold_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.p !== p0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) hold_ok = 1'b0;
    end
    check("bp_hold_stable", hold_ok, 1'b1);
    release_out();
    check("bp_idle_valid", bus.out_valid, 1'b0);
    check("bp_idle_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    collect(p1, lat, busy_ok);
    check("bp_second_p", p1, 64'd77000);
    check("bp_second_lat", lat, exp_lat(2'd0, 32'd77));
    release_out();

    // Reset asserted during the 4th BUSY cycle aborts the request.
    send(2'd0, 32'h1357_9BDF, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", bus.in_ready, 1'b1);
    check("abort_out_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check("abort_no_valid", seen_valid, 1'b0);
    run_op("post_rst_7x6", 2'd0, 32'd7, 32'd6, 1'b1);
    check("post_rst_42", bus.p, 64'd42);

    for (int i = 0; i < 2000; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      send(op, a, b);
      collect(p0, lat, busy_ok);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        if (bus.p !== p0 || !bus.out_valid) busy_ok = 1'b0;
      end
      if (p0 !== ref_mul(op, a, b) || lat != exp_lat(op, b) || !busy_ok)
        $display("rnd %0d: op=%0d a=0x%h b=0x%h", i, op, a, b);
      check("rnd_p", p0, ref_mul(op, a, b));
      check("rnd_lat", lat, exp_lat(op, b));
      check("rnd_hold", busy_ok, 1'b1);
      release_out();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
